// File: rtl/csr_commit_unit.sv
// Commit-side CSR sequencer: read / read-modify-write of the CSR file over a valid/ready channel.
// Optional response timeout enabled by defining CSR_COMMIT_TIMEOUT_EN.
module csr_commit_unit #(
    parameter int XLEN           = 64,
    parameter int TRANS_ID_BITS  = 3,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     commit_valid_i,
    input  logic [1:0]               commit_op_i,
    input  logic [XLEN-1:0]          commit_wdata_i,
    input  logic [TRANS_ID_BITS-1:0] commit_trans_id_i,
    output logic                     commit_ack_o,
    output logic                     commit_ex_o,
    output logic [XLEN-1:0]          commit_rdata_o,
    output logic [TRANS_ID_BITS-1:0] commit_trans_id_o,
    output logic                     csr_commit_o,
    input  logic [11:0]              csr_addr_i,
    output logic                     csr_req_valid_o,
    input  logic                     csr_req_ready_i,
    output logic                     csr_req_we_o,
    output logic [11:0]              csr_req_addr_o,
    output logic [XLEN-1:0]          csr_req_wdata_o,
    input  logic                     csr_rsp_valid_i,
    input  logic [XLEN-1:0]          csr_rsp_rdata_i,
    input  logic                     csr_rsp_err_i
);

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE, DRAIN
    } state_t;

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_SET   = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_t                   r_state;
    logic [1:0]               r_op;
    logic [XLEN-1:0]          r_wdata;
    logic [TRANS_ID_BITS-1:0] r_tid;
    logic [11:0]              r_addr;
    logic [XLEN-1:0]          r_old;
    logic [XLEN-1:0]          r_new;
    logic                     r_ex;

`ifdef CSR_COMMIT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] r_tmo_cnt;
    logic             w_tmo;
    assign w_tmo = (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    logic            w_ro_fault;
    logic            w_skip_wr;
    logic [XLEN-1:0] w_new_val;

    // Writes to the read-only CSR space (addr[11:10]==2'b11) fault without touching the bus.
    assign w_ro_fault = (commit_op_i != OP_READ) && (csr_addr_i[11:10] == 2'b11);
    assign w_skip_wr  = (r_op == OP_READ) ||
                        ((r_op == OP_SET || r_op == OP_CLEAR) && r_wdata == '0);

    always_comb begin
        w_new_val = csr_rsp_rdata_i;
        case (r_op)
            OP_WRITE: w_new_val = r_wdata;
            OP_SET:   w_new_val = csr_rsp_rdata_i | r_wdata;
            OP_CLEAR: w_new_val = csr_rsp_rdata_i & ~r_wdata;
            default:  w_new_val = csr_rsp_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_op    <= OP_READ;
            r_wdata <= '0;
            r_tid   <= '0;
            r_addr  <= '0;
            r_old   <= '0;
            r_new   <= '0;
            r_ex    <= 1'b0;
`ifdef CSR_COMMIT_TIMEOUT_EN
            r_tmo_cnt <= '0;
`endif
        end else begin
`ifdef CSR_COMMIT_TIMEOUT_EN
            // Cleared on every state entry; wait states advance it while they hold.
            r_tmo_cnt <= '0;
`endif
            case (r_state)
                IDLE: begin
                    if (commit_valid_i && !flush_i) begin
                        r_op    <= commit_op_i;
                        r_wdata <= commit_wdata_i;
                        r_tid   <= commit_trans_id_i;
                        r_addr  <= csr_addr_i;
                        r_old   <= '0;
                        r_new   <= '0;
                        r_ex    <= w_ro_fault;
                        r_state <= w_ro_fault ? DONE : RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (flush_i)              r_state <= IDLE;
                    else if (csr_req_ready_i) r_state <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (flush_i) begin
                        r_state <= csr_rsp_valid_i ? IDLE : DRAIN;
                    end else if (csr_rsp_valid_i) begin
                        r_old <= csr_rsp_rdata_i;
                        if (csr_rsp_err_i) begin
                            r_ex    <= 1'b1;
                            r_state <= DONE;
                        end else if (w_skip_wr) begin
                            r_state <= DONE;
                        end else begin
                            r_new   <= w_new_val;
                            r_state <= WR_REQ;
                        end
                    end
`ifdef CSR_COMMIT_TIMEOUT_EN
                    else if (w_tmo) begin
                        r_ex    <= 1'b1;
                        r_old   <= '0;
                        r_state <= DONE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
`endif
                end
                WR_REQ: begin
                    if (flush_i)              r_state <= IDLE;
                    else if (csr_req_ready_i) r_state <= WR_WAIT;
                end
                WR_WAIT: begin
                    if (flush_i) begin
                        r_state <= csr_rsp_valid_i ? IDLE : DRAIN;
                    end else if (csr_rsp_valid_i) begin
                        r_ex    <= csr_rsp_err_i;
                        r_state <= DONE;
                    end
`ifdef CSR_COMMIT_TIMEOUT_EN
                    else if (w_tmo) begin
                        r_ex    <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
`endif
                end
                DONE: r_state <= IDLE;
                DRAIN: begin
                    if (csr_rsp_valid_i) r_state <= IDLE;
`ifdef CSR_COMMIT_TIMEOUT_EN
                    else if (w_tmo)      r_state <= IDLE;
                    else                 r_tmo_cnt <= r_tmo_cnt + 1'b1;
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign commit_ack_o      = (r_state == DONE);
    assign csr_commit_o      = (r_state == DONE);
    assign commit_ex_o       = r_ex;
    assign commit_rdata_o    = r_old;
    assign commit_trans_id_o = r_tid;
    assign csr_req_valid_o   = (r_state == RD_REQ) || (r_state == WR_REQ);
    assign csr_req_we_o      = (r_state == WR_REQ);
    assign csr_req_addr_o    = r_addr;
    assign csr_req_wdata_o   = r_new;

endmodule

// File: tb/tb_csr_commit_unit.sv
// Directed bench for csr_commit_unit: vector table plus hand-written flush/timeout sequences.
module tb_csr_commit_unit;

    logic        clk = 1'b0;
    logic        rst, flush, cv, ready, rspv, rsperr;
    logic [1:0]  op;
    logic [63:0] cwd, rspd;
    logic [2:0]  ctid;
    logic [11:0] addr;
    logic        ack, ex, ccommit, req_valid, req_we;
    logic [63:0] rdata, req_wdata;
    logic [2:0]  tid_o;
    logic [11:0] req_addr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    csr_commit_unit #(.XLEN(64), .TRANS_ID_BITS(3), .TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .commit_valid_i(cv), .commit_op_i(op), .commit_wdata_i(cwd),
        .commit_trans_id_i(ctid), .commit_ack_o(ack), .commit_ex_o(ex),
        .commit_rdata_o(rdata), .commit_trans_id_o(tid_o), .csr_commit_o(ccommit),
        .csr_addr_i(addr), .csr_req_valid_o(req_valid), .csr_req_ready_i(ready),
        .csr_req_we_o(req_we), .csr_req_addr_o(req_addr), .csr_req_wdata_o(req_wdata),
        .csr_rsp_valid_i(rspv), .csr_rsp_rdata_i(rspd), .csr_rsp_err_i(rsperr)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [11:0] addr;
        logic [63:0] wd;
        logic [63:0] rd;        // read response data
        logic        rd_err;
        logic        wr_err;
        int          stall;     // cycles ready is held low in WR_REQ
        int          ack_cyc;
        logic [63:0] exp_rdata;
        logic        exp_ex;
        int          exp_nreq;
        logic [63:0] exp_wr;
    } vec_t;

    vec_t vecs[9];

    // Drives one instruction with an ideal responder (rsp one cycle after accept).
    task automatic run_vec(input vec_t v, input logic [2:0] tid, input string name);
        int cyc = 0, nreq = 0, stall = v.stall;
        bit acked = 0, acc_prev = 0, acc_we = 0, stalled = 0;
        logic [63:0] wdat = '0, swd = '0;
        logic [11:0] sa = '0;
        @(negedge clk);
        cv = 1; op = v.op; cwd = v.wd; ctid = tid; addr = v.addr; ready = 1; rspv = 0;
        while (!acked && cyc < 60) begin
            @(negedge clk);
            cyc++;
            rspv = 0;
            if (acc_prev) begin
                rspv   = 1;
                rspd   = acc_we ? 64'hBAD : v.rd;
                rsperr = acc_we ? v.wr_err : v.rd_err;
            end
            acc_prev = 0;
            ready    = 1;
            if (req_valid) begin
                chk({name, " req_addr"}, req_addr, v.addr);
                if (req_we && stall > 0) begin
                    if (!stalled) begin
                        sa = req_addr; swd = req_wdata; stalled = 1;
                    end else begin
                        chk({name, " stall wdata"}, req_wdata, swd);
                        chk({name, " stall addr"}, req_addr, sa);
                    end
                    ready = 0;
                    stall--;
                end else begin
                    acc_prev = 1; acc_we = req_we; nreq++;
                    if (req_we) wdat = req_wdata;
                    else chk({name, " first req is read"}, 64'(nreq), 64'd1);
                end
            end
            chk({name, " csr_commit==ack"}, 64'(ccommit), 64'(ack));
            if (ack) begin
                acked = 1;
                chk({name, " ack cycle"}, 64'(cyc), 64'(v.ack_cyc));
                chk({name, " rdata"}, rdata, v.exp_rdata);
                chk({name, " ex"}, 64'(ex), 64'(v.exp_ex));
                chk({name, " trans_id"}, 64'(tid_o), 64'(tid));
            end
        end
        if (!acked) begin
            failures++;
            $display("FAIL %s: no ack within 60 cycles", name);
        end
        chk({name, " request count"}, 64'(nreq), 64'(v.exp_nreq));
        if (v.exp_nreq == 2) chk({name, " write data"}, wdat, v.exp_wr);
        chk({name, " stall remaining"}, 64'(stall), 64'd0);
        cv = 0; rspv = 0; rsperr = 0;
        @(negedge clk);
        chk({name, " ack one pulse"}, 64'(ack), 64'd0);
    endtask

    initial begin
        //                op     addr     wd        rd        rerr werr stall ack rdata    ex nreq wr
        vecs[0] = '{2'd0, 12'h300, 64'h0,    64'hA5,   0, 0, 0, 3,  64'hA5,   0, 1, 64'h0};
        vecs[1] = '{2'd2, 12'h300, 64'h0F,   64'hF0,   0, 0, 0, 5,  64'hF0,   0, 2, 64'hFF};
        vecs[2] = '{2'd3, 12'h300, 64'h30,   64'hFF,   0, 0, 0, 5,  64'hFF,   0, 2, 64'hCF};
        vecs[3] = '{2'd1, 12'hC00, 64'h1,    64'h77,   0, 0, 0, 1,  64'h0,    1, 0, 64'h0};
        vecs[4] = '{2'd2, 12'h300, 64'h0,    64'h12,   0, 0, 0, 3,  64'h12,   0, 1, 64'h0};
        vecs[5] = '{2'd1, 12'h305, 64'hDEAD, 64'h77,   0, 0, 0, 5,  64'h77,   0, 2, 64'hDEAD};
        vecs[6] = '{2'd0, 12'hC00, 64'h0,    64'h55,   0, 0, 0, 3,  64'h55,   0, 1, 64'h0};
        vecs[7] = '{2'd0, 12'h7B0, 64'h0,    64'h99,   1, 0, 0, 3,  64'h99,   1, 1, 64'h0};
        vecs[8] = '{2'd2, 12'h300, 64'h0F,   64'hF0,   0, 1, 5, 10, 64'hF0,   1, 2, 64'hFF};

        rst = 1; flush = 0; cv = 0; op = 0; cwd = 0; ctid = 0; addr = 0;
        ready = 1; rspv = 0; rspd = 0; rsperr = 0;
        repeat (3) @(negedge clk);
        chk("reset ack", 64'(ack), 0);
        chk("reset ex", 64'(ex), 0);
        chk("reset rdata", rdata, 0);
        chk("reset tid", 64'(tid_o), 0);
        chk("reset csr_commit", 64'(ccommit), 0);
        chk("reset req_valid", 64'(req_valid), 0);
        chk("reset req_we", 64'(req_we), 0);
        chk("reset req_addr", 64'(req_addr), 0);
        chk("reset req_wdata", req_wdata, 0);
        rst = 0;

        // Unsolicited response in IDLE must be ignored.
        @(negedge clk); rspv = 1; rspd = 64'h42;
        @(negedge clk); rspv = 0;
        chk("unsolicited ack", 64'(ack), 0);
        chk("unsolicited req_valid", 64'(req_valid), 0);

        for (int i = 0; i < 9; i++)
            run_vec(vecs[i], 3'(i), $sformatf("vec%0d", i));

        // Flush in RD_WAIT, response three cycles later goes through DRAIN.
        @(negedge clk); cv = 1; op = 0; addr = 12'h300; ctid = 3'd5; ready = 1;
        @(negedge clk); chk("fw c1 req_valid", 64'(req_valid), 1);
        @(negedge clk); chk("fw c2 req_valid", 64'(req_valid), 0); flush = 1;
        @(negedge clk); flush = 0; cv = 0; chk("fw c3 ack", 64'(ack), 0);
        @(negedge clk); chk("fw c4 ack", 64'(ack), 0); chk("fw c4 req_valid", 64'(req_valid), 0);
        @(negedge clk); rspv = 1; rspd = 64'h1234; chk("fw c5 ack", 64'(ack), 0);
        @(negedge clk); rspv = 0;
        chk("fw c6 ack", 64'(ack), 0);
        chk("fw c6 csr_commit", 64'(ccommit), 0);
        chk("fw c6 req_valid", 64'(req_valid), 0);
        run_vec(vecs[0], 3'd6, "after flush wait");

        // Flush in RD_REQ: valid drops the next cycle.
        @(negedge clk); cv = 1; op = 0; addr = 12'h300; ctid = 3'd1;
        @(negedge clk); chk("fr c1 req_valid", 64'(req_valid), 1); flush = 1; ready = 0;
        @(negedge clk); chk("fr c2 req_valid", 64'(req_valid), 0);
        chk("fr c2 ack", 64'(ack), 0); flush = 0; cv = 0; ready = 1;
        @(negedge clk); chk("fr c3 req_valid", 64'(req_valid), 0); chk("fr c3 ack", 64'(ack), 0);
        run_vec(vecs[1], 3'd2, "after flush req");

        // Flush and response in the same RD_WAIT cycle: straight back to IDLE.
        @(negedge clk); cv = 1; op = 0; addr = 12'h300; ctid = 3'd3;
        @(negedge clk);
        @(negedge clk); flush = 1; rspv = 1; rspd = 64'h5;
        @(negedge clk); flush = 0; rspv = 0; cv = 0; chk("fsame ack", 64'(ack), 0);
        run_vec(vecs[6], 3'd4, "after flush+rsp");

`ifdef CSR_COMMIT_TIMEOUT_EN
        begin
            int  cyc = 0;
            bit  acked = 0;
            @(negedge clk); cv = 1; op = 0; addr = 12'h300; ctid = 3'd7; ready = 1;
            while (!acked && cyc < 40) begin
                @(negedge clk);
                cyc++;
                if (ack) begin
                    acked = 1;
                    chk("tmo ack cycle", 64'(cyc), 64'd18);
                    chk("tmo ex", 64'(ex), 1);
                    chk("tmo rdata", rdata, 0);
                end
            end
            if (!acked) begin
                failures++;
                $display("FAIL tmo: no ack within 40 cycles");
            end
            cv = 0;
            @(negedge clk); rspv = 1; rspd = 64'hEE;
            @(negedge clk); rspv = 0; chk("tmo late rsp ack", 64'(ack), 0);
            @(negedge clk); chk("tmo late rsp ack2", 64'(ack), 0);
            run_vec(vecs[0], 3'd0, "after timeout");
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/csr_commit_unit.md
# csr_commit_unit

Commit-side sequencer for CSR instructions. When the head of the commit window is a CSR instruction, it reads the address held by the CSR buffer and performs the read / read-modify-write against the CSR register file over a valid/ready request and response channel. On completion it returns the old CSR value and an exception flag to commit, and pulses `csr_commit_o` to release the CSR buffer.

## Interface
Parameters:
- `XLEN`, default 64: CSR data width.
- `TRANS_ID_BITS`, default 3: scoreboard transaction ID width.
- `TIMEOUT_CYCLES`, default 16: maximum response wait; must be ≥2.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `flush_i` in 1: abort the current instruction.
- `commit_valid_i` in 1: head instruction is a CSR op; held until `commit_ack_o`.
- `commit_op_i` in 2: 0 READ, 1 WRITE, 2 SET, 3 CLEAR.
- `commit_wdata_i` in XLEN: source operand.
- `commit_trans_id_i` in TRANS_ID_BITS: instruction ID.
- `commit_ack_o` out 1: one-cycle retire pulse.
- `commit_ex_o` out 1: exception; valid with `commit_ack_o`.
- `commit_rdata_o` out XLEN: old CSR value; valid with ack.
- `commit_trans_id_o` out TRANS_ID_BITS: ID echoed with ack.
- `csr_commit_o` out 1: buffer release; same cycle as `commit_ack_o`.
- `csr_addr_i` in 12: buffered CSR address; stable until `csr_commit_o`.
- `csr_req_valid_o` out 1: request valid.
- `csr_req_ready_i` in 1: request accepted.
- `csr_req_we_o` out 1: 1 write, 0 read.
- `csr_req_addr_o` out 12: request address.
- `csr_req_wdata_o` out XLEN: write data.
- `csr_rsp_valid_i` in 1: response valid, one cycle.
- `csr_rsp_rdata_i` in XLEN: read data.
- `csr_rsp_err_i` in 1: access fault, for example a nonexistent CSR or a privilege violation.

## Operation
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE, DRAIN.
- IDLE:
  - On `commit_valid_i && !flush_i`, latch op, wdata, trans_id and `csr_addr_i`.
  - If op≠READ and addr[11:10]==2'b11 (read-only CSR): go to DONE with ex=1 and rdata=0. No request is issued.
  - Otherwise go to RD_REQ.
- RD_REQ: `csr_req_valid_o`=1, we=0. When ready is sampled high, go to RD_WAIT.
- RD_WAIT: on `csr_rsp_valid_i`, latch rdata into old.
  - If err: go to DONE with ex=1.
  - Else if op==READ, or op∈{SET,CLEAR} with wdata==0: go to DONE with ex=0.
  - Else: go to WR_REQ with new value computed as:
    - WRITE: wdata.
    - SET: old | wdata.
    - CLEAR: old & ~wdata.
- WR_REQ: valid=1, we=1, wdata=new. When ready is high, go to WR_WAIT.
- WR_WAIT: on rsp, go to DONE; ex=err. rdata stays old; the write response data is ignored.
- DONE: pulse `commit_ack_o` and `csr_commit_o` for one cycle, then return to IDLE. `commit_rdata_o`, `commit_ex_o` and `commit_trans_id_o` come from the latched registers.
- Request stability: request fields are constant while valid && !ready. The only exception is flush.
- Flush behaviour:
  - In RD_REQ or WR_REQ, a flush drops valid next cycle and returns to IDLE.
  - In RD_WAIT or WR_WAIT, a flush goes to DRAIN. DRAIN waits for `csr_rsp_valid_i` and discards it, then goes to IDLE.
  - In DONE, flush is ignored: the ack still fires.
  - A flushed instruction never produces `commit_ack_o` or `csr_commit_o`.
  - Flush has priority over a same-cycle ready or rsp in REQ/WAIT states. In WAIT states the response is then discarded and the FSM returns to IDLE without entering DRAIN.
- Unsolicited `csr_rsp_valid_i` in IDLE, RD_REQ or WR_REQ is ignored.

## Timing
- Reset: state=IDLE and every output is 0, including `csr_req_addr_o`, `csr_req_wdata_o`, `commit_rdata_o` and `commit_trans_id_o`.
- All outputs are registered or decoded from state; there are no combinational input-to-output paths.
- With ready high and response one cycle after accept (accept at cycle t, earliest rsp at t+1), cycle counts from `commit_valid_i` sampled in IDLE at cycle 0:
  - READ: RD_REQ c1, RD_WAIT c2 (rsp), DONE c3, so ack at c3.
  - WRITE/SET/CLEAR: WR_REQ c3, WR_WAIT c4 (rsp), ack at c5.
  - Read-only fault: ack at c1.
- A new instruction can be accepted in the IDLE cycle after DONE, so the minimum spacing between acks is 4 cycles (READ).
- Reset mid-operation: immediate return to IDLE. Any outstanding response is not drained; the CSR file is reset together with this unit.

## Configuration
- `CSR_COMMIT_TIMEOUT_EN` defined:
  - A counter, cleared on each state entry, counts cycles spent in RD_WAIT, WR_WAIT or DRAIN.
  - On reaching `TIMEOUT_CYCLES` without rsp: RD_WAIT/WR_WAIT go to DONE with ex=1 and rdata=0 if no read data was captured; DRAIN goes to IDLE.
  - A response arriving after a timeout is ignored.
- Undefined: no counter; the FSM waits indefinitely.

## Test plan
- READ of addr 0x300, rsp rdata=0xA5: ack at c3, rdata=0xA5, ex=0, one request only with we=0, `csr_commit_o` coincident with ack.
- SET of 0x300 with wdata=0x0F, old=0xF0: write request carries 0xFF, ack at c5, rdata=0xF0. Repeat with CLEAR and wdata=0x30, old=0xFF: write carries 0xCF.
- WRITE to 0xC00: no request issued, ack at c1 with ex=1 and rdata=0. SET to 0x300 with wdata=0: read only, no write.
- `csr_req_ready_i` held low for 5 cycles in WR_REQ: fields stay stable and valid stays high; `csr_rsp_err_i`=1 on the write rsp gives ex=1.
- flush in RD_WAIT, rsp 3 cycles later: no ack, returns to IDLE after rsp, and the next instruction completes normally. flush in RD_REQ: valid drops next cycle.
- With `CSR_COMMIT_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, no rsp: ack with ex=1 after 16 cycles in RD_WAIT; a late rsp is ignored.
